// File: rtl/raycast_pkg.sv
// Shared raycaster types: world size, Q8.8 distance format, tracing FSM states.
// No logic, so no latency; no flow control of its own.
package raycast_pkg;
  localparam int WORLD_X   = 16;
  localparam int WORLD_Y   = 16;
  localparam int FRAC_BITS = 8;
  localparam int DW        = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STEP,
    PROBE,
    CHECK,
    DONE
  } ray_state_e;
endpackage

// File: rtl/ray_dda_stepper_sat_add.sv
// Unsigned saturating adder; pure combinational, zero latency.
// Clamps at all-ones instead of wrapping; no flow control.
module sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);
  logic [W:0] full;

  assign full  = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o = full[W] ? {W{1'b1}} : full[W-1:0];
endmodule

// File: rtl/ray_dda_stepper.sv
// DDA grid walker: one ray at a time, wall on step k gives done in cycle 2k+3.
// Busy while tracing; a start that arrives while busy is dropped, never queued.
module ray_dda_stepper
  import raycast_pkg::*;
#(
  parameter int MAX_STEPS = 32,
  parameter int DW        = raycast_pkg::DW
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          start_i,
  input  logic [3:0]    map_x0_i,
  input  logic [3:0]    map_y0_i,
  input  logic          step_x_neg_i,
  input  logic          step_y_neg_i,
  input  logic [DW-1:0] delta_x_i,
  input  logic [DW-1:0] delta_y_i,
  input  logic [DW-1:0] side_x0_i,
  input  logic [DW-1:0] side_y0_i,
  output logic [3:0]    x_pos_o,
  output logic [3:0]    y_pos_o,
  output logic          is_new_ray_o,
  input  logic          is_wall_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [3:0]    hit_x_o,
  output logic [3:0]    hit_y_o,
  output logic          hit_side_o,
  output logic [DW-1:0] perp_dist_o,
  output logic          miss_o
);
  localparam int CW = $clog2(MAX_STEPS + 1);

  ray_state_e    state_q, state_d;
  logic [3:0]    map_x_q, map_x_d, map_y_q, map_y_d;
  logic [DW-1:0] side_x_q, side_x_d, side_y_q, side_y_d;
  logic [DW-1:0] delta_x_q, delta_x_d, delta_y_q, delta_y_d;
  logic          neg_x_q, neg_x_d, neg_y_q, neg_y_d;
  logic          axis_q, axis_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] sum_x, sum_y, perp_d;
  logic          do_step, miss_d;

  logic [3:0]    x_pos_q, y_pos_q, hit_x_q, hit_y_q;
  logic          busy_q, done_q, new_ray_q, hit_side_q, miss_q;
  logic [DW-1:0] perp_q;

  sat_add #(.W(DW)) u_sat_x (.a_i(side_x_q), .b_i(delta_x_q), .sum_o(sum_x));
  sat_add #(.W(DW)) u_sat_y (.a_i(side_y_q), .b_i(delta_y_q), .sum_o(sum_y));

  always_comb begin
    state_d   = state_q;
    map_x_d   = map_x_q;
    map_y_d   = map_y_q;
    side_x_d  = side_x_q;
    side_y_d  = side_y_q;
    delta_x_d = delta_x_q;
    delta_y_d = delta_y_q;
    neg_x_d   = neg_x_q;
    neg_y_d   = neg_y_q;
    axis_d    = axis_q;
    cnt_d     = cnt_q;
    do_step   = 1'b0;
    miss_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = CLEAR;
          map_x_d   = map_x0_i;
          map_y_d   = map_y0_i;
          side_x_d  = side_x0_i;
          side_y_d  = side_y0_i;
          delta_x_d = delta_x_i;
          delta_y_d = delta_y_i;
          neg_x_d   = step_x_neg_i;
          neg_y_d   = step_y_neg_i;
          cnt_d     = '0;
        end
      end
      CLEAR: state_d = STEP;
      STEP: begin
        do_step = 1'b1;
        state_d = PROBE;
      end
      PROBE: state_d = CHECK;
      CHECK: begin
        if (is_wall_i) begin
          state_d = DONE;
        end else if (cnt_q == CW'(MAX_STEPS)) begin
          state_d = DONE;
          miss_d  = 1'b1;
        end else begin
          do_step = 1'b1;
          state_d = PROBE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Ties step along y; 4-bit map coordinates wrap naturally.
    if (do_step) begin
      if (side_x_q < side_y_q) begin
        side_x_d = sum_x;
        map_x_d  = neg_x_q ? map_x_q - 4'd1 : map_x_q + 4'd1;
        axis_d   = 1'b0;
      end else begin
        side_y_d = sum_y;
        map_y_d  = neg_y_q ? map_y_q - 4'd1 : map_y_q + 4'd1;
        axis_d   = 1'b1;
      end
      cnt_d = cnt_q + CW'(1);
    end

    if (!axis_q) perp_d = (side_x_q > delta_x_q) ? side_x_q - delta_x_q : '0;
    else         perp_d = (side_y_q > delta_y_q) ? side_y_q - delta_y_q : '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      map_x_q    <= '0;
      map_y_q    <= '0;
      side_x_q   <= '0;
      side_y_q   <= '0;
      delta_x_q  <= '0;
      delta_y_q  <= '0;
      neg_x_q    <= 1'b0;
      neg_y_q    <= 1'b0;
      axis_q     <= 1'b0;
      cnt_q      <= '0;
      x_pos_q    <= '0;
      y_pos_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      new_ray_q  <= 1'b0;
      hit_x_q    <= '0;
      hit_y_q    <= '0;
      hit_side_q <= 1'b0;
      perp_q     <= '0;
      miss_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      map_x_q   <= map_x_d;
      map_y_q   <= map_y_d;
      side_x_q  <= side_x_d;
      side_y_q  <= side_y_d;
      delta_x_q <= delta_x_d;
      delta_y_q <= delta_y_d;
      neg_x_q   <= neg_x_d;
      neg_y_q   <= neg_y_d;
      axis_q    <= axis_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      new_ray_q <= (state_d == CLEAR);
      if (do_step) begin
        x_pos_q <= map_x_d;
        y_pos_q <= map_y_d;
      end
      if (state_q == CHECK && state_d == DONE) begin
        hit_x_q    <= map_x_q;
        hit_y_q    <= map_y_q;
        hit_side_q <= axis_q;
        perp_q     <= perp_d;
        miss_q     <= miss_d;
      end
    end
  end

  assign x_pos_o      = x_pos_q;
  assign y_pos_o      = y_pos_q;
  assign is_new_ray_o = new_ray_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign hit_x_o      = hit_x_q;
  assign hit_y_o      = hit_y_q;
  assign hit_side_o   = hit_side_q;
  assign perp_dist_o  = perp_q;
  assign miss_o       = miss_q;
endmodule

// File: tb/tb_ray_dda_stepper.sv
// Scoreboarded bench for ray_dda_stepper with a registered world-map model.
module tb_ray_dda_stepper;
  localparam int MAX_STEPS = 32;
  localparam int DW        = 16;

  typedef struct {
    int hx; int hy; int side; int perp; int miss; int cyc;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          start_i = 1'b0;
  logic [3:0]    map_x0_i = '0, map_y0_i = '0;
  logic          step_x_neg_i = 1'b0, step_y_neg_i = 1'b0;
  logic [DW-1:0] delta_x_i = '0, delta_y_i = '0, side_x0_i = '0, side_y0_i = '0;
  logic [3:0]    x_pos_o, y_pos_o, hit_x_o, hit_y_o;
  logic          is_new_ray_o, busy_o, done_o, hit_side_o, miss_o;
  logic          is_wall_i = 1'b0;
  logic [DW-1:0] perp_dist_o;

  logic wall_map [256];
  exp_t sb_q[$];
  int   n_vec = 0, n_err = 0, done_cnt = 0, rays_done = 0;

  ray_dda_stepper #(.MAX_STEPS(MAX_STEPS), .DW(DW)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
    .map_x0_i(map_x0_i), .map_y0_i(map_y0_i),
    .step_x_neg_i(step_x_neg_i), .step_y_neg_i(step_y_neg_i),
    .delta_x_i(delta_x_i), .delta_y_i(delta_y_i),
    .side_x0_i(side_x0_i), .side_y0_i(side_y0_i),
    .x_pos_o(x_pos_o), .y_pos_o(y_pos_o), .is_new_ray_o(is_new_ray_o),
    .is_wall_i(is_wall_i), .busy_o(busy_o), .done_o(done_o),
    .hit_x_o(hit_x_o), .hit_y_o(hit_y_o), .hit_side_o(hit_side_o),
    .perp_dist_o(perp_dist_o), .miss_o(miss_o)
  );

  always #5 clk_i = ~clk_i;

  // World lookup: wall flag registered one cycle after the presented cell.
  always @(posedge clk_i) is_wall_i <= wall_map[{y_pos_o, x_pos_o}];

  always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_walls();
    foreach (wall_map[i]) wall_map[i] = 1'b0;
  endtask

  task automatic set_wall(input int x, input int y);
    wall_map[y * 16 + x] = 1'b1;
  endtask

  function automatic exp_t model(input int mx, input int my, input int nx, input int ny,
                                 input int dx, input int dy, input int sx, input int sy);
    exp_t e;
    int side = 0;
    for (int k = 1; k <= MAX_STEPS; k++) begin
      if (sx < sy) begin
        sx = (sx + dx > 65535) ? 65535 : sx + dx;
        mx = nx ? (mx + 15) % 16 : (mx + 1) % 16;
        side = 0;
      end else begin
        sy = (sy + dy > 65535) ? 65535 : sy + dy;
        my = ny ? (my + 15) % 16 : (my + 1) % 16;
        side = 1;
      end
      e.hx = mx; e.hy = my; e.side = side;
      e.perp = (side == 0) ? ((sx > dx) ? sx - dx : 0) : ((sy > dy) ? sy - dy : 0);
      if (wall_map[my * 16 + mx]) begin
        e.miss = 0; e.cyc = 2 * k + 3;
        return e;
      end
    end
    e.miss = 1; e.cyc = 2 * MAX_STEPS + 3;
    return e;
  endfunction

  task automatic drive_start(input int mx, input int my, input int nx, input int ny,
                             input int dx, input int dy, input int sx, input int sy);
    @(negedge clk_i);
    map_x0_i = 4'(mx); map_y0_i = 4'(my);
    step_x_neg_i = 1'(nx); step_y_neg_i = 1'(ny);
    delta_x_i = 16'(dx); delta_y_i = 16'(dy);
    side_x0_i = 16'(sx); side_y0_i = 16'(sy);
    start_i = 1'b1;
  endtask

  // poke=1 re-pulses start mid-ray with different inputs; it must be ignored.
  task automatic run_ray(input string nm, input int mx, input int my, input int nx, input int ny,
                         input int dx, input int dy, input int sx, input int sy, input bit poke);
    exp_t e;
    int   cyc;
    bit   seen = 0;
    drive_start(mx, my, nx, ny, dx, dy, sx, sy);
    sb_q.push_back(model(mx, my, nx, ny, dx, dy, sx, sy));
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 1;
    chk({nm, "_newray_c1"}, 32'(is_new_ray_o), 1);
    chk({nm, "_busy_c1"}, 32'(busy_o), 1);
    while (!seen && cyc < 200) begin
      if (done_o === 1'b1) begin
        seen = 1;
        e = sb_q.pop_front();
        rays_done++;
        chk({nm, "_cycle"}, cyc, e.cyc);
        chk({nm, "_hit_x"}, 32'(hit_x_o), e.hx);
        chk({nm, "_hit_y"}, 32'(hit_y_o), e.hy);
        chk({nm, "_side"}, 32'(hit_side_o), e.side);
        chk({nm, "_perp"}, 32'(perp_dist_o), e.perp);
        chk({nm, "_miss"}, 32'(miss_o), e.miss);
      end else begin
        if (cyc > 1 && is_new_ray_o !== 1'b0) chk({nm, "_newray_extra"}, 32'(is_new_ray_o), 0);
        @(negedge clk_i);
        cyc++;
        start_i = (poke && cyc == 3) ? 1'b1 : 1'b0;
        if (poke && cyc == 3) begin
          map_x0_i = 4'd0; map_y0_i = 4'd0; side_x0_i = 16'h0001;
        end
      end
    end
    start_i = 1'b0;
    if (!seen) begin
      chk({nm, "_done_timeout"}, 0, 1);
      void'(sb_q.pop_front());
    end else begin
      @(negedge clk_i);
      chk({nm, "_done_pulse"}, 32'(done_o), 0);
      chk({nm, "_busy_after"}, 32'(busy_o), 0);
      chk({nm, "_hold_x"}, 32'(hit_x_o), e.hx);
    end
  endtask

  initial begin
    clear_walls();
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_newray", 32'(is_new_ray_o), 0);
    chk("rst_pos", 32'({x_pos_o, y_pos_o}), 0);
    chk("rst_hit", 32'({hit_x_o, hit_y_o, hit_side_o, miss_o}), 0);
    chk("rst_perp", 32'(perp_dist_o), 0);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    clear_walls(); set_wall(6, 5);
    run_ray("east", 5, 5, 0, 0, 'h100, 'h100, 'h080, 'h200, 0);

    clear_walls(); set_wall(5, 6);
    run_ray("tie", 5, 5, 0, 0, 'h100, 'h100, 'h100, 'h100, 0);

    clear_walls(); set_wall(8, 7);
    run_ray("diag", 5, 5, 0, 0, 'h100, 'h100, 'h080, 'h100, 1);

    clear_walls();
    run_ray("open", 5, 5, 0, 0, 'h100, 'h100, 'h080, 'h100, 0);

    clear_walls(); set_wall(6, 5);
    run_ray("satx", 5, 5, 0, 0, 'hFF00, 'h100, 'hFF00, 'hFFFF, 0);

    clear_walls(); set_wall(6, 6);
    run_ray("saty", 5, 5, 0, 0, 'hFF00, 'h100, 'hFF00, 'hFFFF, 0);

    clear_walls(); set_wall(2, 9);
    run_ray("negxy", 4, 11, 1, 1, 'h100, 'h100, 'h080, 'h0C0, 0);

    // Abort a ray in PROBE with reset, then trace a fresh one.
    clear_walls(); set_wall(9, 5);
    drive_start(5, 5, 0, 0, 'h100, 'h100, 'h080, 'h200);
    @(negedge clk_i); start_i = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    chk("abort_busy_probe", 32'(busy_o), 1);
    reset_n_i = 1'b0;
    #1;
    chk("abort_busy_rst", 32'(busy_o), 0);
    chk("abort_pos_rst", 32'({x_pos_o, y_pos_o}), 0);
    @(negedge clk_i); reset_n_i = 1'b1;
    repeat (12) @(negedge clk_i);
    chk("abort_no_done", done_cnt, rays_done);
    run_ray("after_rst", 5, 5, 0, 0, 'h100, 'h100, 'h080, 'h200, 0);

    for (int r = 0; r < 4; r++) begin
      clear_walls();
      for (int i = 0; i < 16; i++) begin
        set_wall(i, 0); set_wall(i, 15); set_wall(0, i); set_wall(15, i);
      end
      for (int i = 0; i < 12; i++) set_wall($urandom_range(1, 14), $urandom_range(1, 14));
      run_ray("rand", $urandom_range(1, 14), $urandom_range(1, 14),
              $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range('h40, 'h300), $urandom_range('h40, 'h300),
              $urandom_range(0, 'h40), $urandom_range(0, 'h40), 0);
    end

    chk("done_count", done_cnt, rays_done);
    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
